// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer.
//   - opcode encodings (OP_ADD .. OP_ASR)
//   - flag bit positions inside the 4-bit {C,V,N,Z} flag vector
//   - sequencer FSM state type
//   - is_shift(): true for the opcodes the sequencer repeats under a counter
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command / response / debug bundle of alu_sequencer.
//   cmd_*  : command stream (valid/ready), master drives, slave accepts
//   rsp_*  : response stream (valid/ready), slave drives, master consumes
//   dbg_*  : combinational register file read port
// master = command issuer (testbench / upstream), slave = alu_sequencer.
interface alu_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = 2,
  parameter int unsigned CNT_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [AW-1:0]     cmd_dst;
  logic [AW-1:0]     cmd_srca;
  logic [AW-1:0]     cmd_srcb;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] cmd_imm;
  logic [CNT_W-1:0]  cmd_count;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rsp_flags;
  logic [AW-1:0]     dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_use_imm,
           cmd_imm, cmd_count, rsp_ready, dbg_addr,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags, dbg_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_use_imm,
           cmd_imm, cmd_count, rsp_ready, dbg_addr,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags, dbg_data
  );
endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU.
//   a, b  : operands
//   op    : opcode (alu_pkg OP_*)
//   y     : result, wraps at DATA_W bits
//   flags : {C,V,N,Z}; C = carry (ADD), borrow (SUB), bit shifted out (SHL/ASR)
//           V = signed overflow for ADD/SUB, 0 otherwise
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y,
  output logic [3:0]        flags
);

  localparam int unsigned MSB = DATA_W - 1;

  logic c;
  logic v;

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        {c, y} = {1'b0, a} + {1'b0, b};
        v = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // extended subtraction: top bit is the borrow (A < B unsigned)
        {c, y} = {1'b0, a} - {1'b0, b};
        v = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: begin
        y = {a[MSB-1:0], 1'b0};
        c = a[MSB];
      end
      default: begin
        y = {a[MSB], a[MSB:1]};
        c = a[0];
      end
    endcase
    flags         = '0;
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
    flags[FLAG_N] = y[MSB];
    flags[FLAG_Z] = (y == '0);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven front end for the combinational alu.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : alu_sequencer_if slave modport
//              cmd_* accepted in IDLE; operands read from the register file
//              at accept; shifts repeated cmd_count times (0 -> 1);
//              result written to reg[dst] and returned on rsp_*;
//              dbg_data is a combinational read of reg[dbg_addr].
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);

  localparam int unsigned AW = $clog2(NREGS);

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [2:0]        op_q;
  logic [AW-1:0]     dst_q;
  logic [CNT_W-1:0]  passes_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [3:0]        rsp_flags_q;

  logic [DATA_W-1:0] alu_y;
  logic [3:0]        alu_flags;
  logic              last_pass;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (alu_y),
    .flags (alu_flags)
  );

  assign last_pass = (passes_q == CNT_W'(1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = EXEC;
      EXEC:    if (last_pass)     state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_flags = rsp_flags_q;
    bus.dbg_data  = regs[bus.dbg_addr];
  end

  // datapath: operand latch, pass counter, register file, response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      dst_q       <= '0;
      passes_q    <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q     <= bus.cmd_op;
            dst_q    <= bus.cmd_dst;
            a_q      <= regs[bus.cmd_srca];
            b_q      <= bus.cmd_use_imm ? bus.cmd_imm : regs[bus.cmd_srcb];
            passes_q <= (is_shift(bus.cmd_op) && (bus.cmd_count != '0))
                        ? bus.cmd_count : CNT_W'(1);
          end
        end
        EXEC: begin
          passes_q <= passes_q - CNT_W'(1);
          // a multi-pass shift feeds each single-bit result back as operand A
          if (is_shift(op_q)) a_q <= alu_y;
          if (last_pass) begin
            regs[dst_q] <= alu_y;
            rsp_data_q  <= alu_y;
            rsp_flags_q <= alu_flags;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven front end for the combinational 16-bit `alu`: accepts operation commands over a valid/ready stream, drives the ALU operands and opcode from a small internal register file, captures the result and flags, writes back, and returns a response over a second valid/ready stream. It is the initiator side of the ALU's operand/opcode interface. It adds multi-pass shifts by repeating ALU op 110/111 under a counter.

## Interface
Parameters:
- `DATA_W`, 16, operand/result width; must match `alu`.
- `NREGS`, 4, register file depth.
- `CNT_W`, 4, shift repeat-count width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer accepts command this cycle.
- `cmd_op`  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 ASR.
- `cmd_dst`  in  2  destination register index.
- `cmd_srca`  in  2  operand-A register index.
- `cmd_srcb`  in  2  operand-B register index.
- `cmd_use_imm`  in  1  1: operand B = `cmd_imm`; 0: register `cmd_srcb`.
- `cmd_imm`  in  16  immediate operand.
- `cmd_count`  in  4  shift repeat count for 110/111; 0 treated as 1; ignored for other ops.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_data`  out  16  final result Y.
- `rsp_flags`  out  4  {C,V,N,Z} from final ALU pass.
- `dbg_addr`  in  2  register file read address.
- `dbg_data`  out  16  combinational read of register `dbg_addr`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch op, dst, A=reg[srca], B=(use_imm ? imm : reg[srcb]), passes = (op is 110/111) ? max(count,1) : 1 → EXEC.
- EXEC: ALU driven from latched A, B, op. Each cycle decrements passes; for shifts A ← Y. On the cycle passes==1: reg[dst] ← Y, rsp_data ← Y, rsp_flags ← {C,V,N,Z} → RESP.
- RESP: `rsp_valid`=1; `rsp_data`/`rsp_flags` held stable until `rsp_ready`; on handshake → IDLE.
- Operands are read at accept, so dst == srca/srcb is legal; the write takes effect on the final EXEC cycle and is visible on `dbg_data` the next cycle.
- Multi-pass shift flags: C = bit shifted out on final pass; V = 0; N, Z from final Y.
- Arithmetic is the ALU's: 16-bit wrap, C = carry (ADD) or borrow (SUB, 1 when A<B unsigned).

## Timing
- Reset values: state IDLE, all registers 0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_flags`=0, `dbg_data`=0.
- Accept at cycle T; EXEC T+1…T+n (n = passes); `rsp_valid` first high at T+n+1.
- Throughput: one command per n+2 cycles with `rsp_ready` held high. `cmd_ready`=0 in EXEC and RESP; no overlap.
- `cmd_ready` is a pure function of state and does not depend on `cmd_valid`. `rsp_valid` is not withdrawn before the handshake.
- `rst` in any state: return to IDLE next cycle. Any in-flight command is dropped with no register write and no response. The register file is cleared.
- `rst` and `cmd_valid` in the same cycle: the command is not accepted.

## Structure
- Shared package `alu_pkg`: opcode localparams (OP_ADD…OP_ASR), flag bit indices (FLAG_C=3, FLAG_V=2, FLAG_N=1, FLAG_Z=0), FSM state enum.
- Single sub-module: instance of combinational `alu`. Register file, counter and FSM are inline.

## Test plan
- Reset; OR r0←r0|imm 0x7FFF; ADD r1←r0+imm 0x0001 → rsp_data 0x8000, flags C0 V1 N1 Z0; dbg r1=0x8000.
- After reset, SUB r2←r3−imm 0x0001 → 0xFFFF, flags C1 V0 N1 Z0.
- r0=0x1234; SHL r1←r0, count 4 → 0x2340, flags C1 V0 N0 Z0. Accept at T; rsp_valid at T+5.
- r0=0x8001; ASR r0←r0, count 0 (single pass) → 0xC000, flags C1 V0 N1 Z0.
- Hold `rsp_ready`=0 for 3 cycles with `cmd_valid`=1 → rsp_valid, data and flags stable; cmd_ready 0; the second command is accepted only after the handshake.
- SHL count 8 in flight, assert `rst` at EXEC cycle 3 → next cycle IDLE, rsp_valid 0, dst reads 0, cmd_ready 1.
